// File: rtl/regfile_mp_if.sv
// regfile_mp_if -- register-dump stream between regfile_mp and its consumer.
//   slave  (register file side): takes in_dump_req / in_dump_ready, drives
//          out_dump_valid, out_dump_regno, out_dump_value, out_dump_done.
//   master (consumer side): the mirror image.
interface regfile_mp_if #(
  parameter int unsigned REGISTER_WIDTH   = 64,
  parameter int unsigned REGISTERNO_WIDTH = 5
);
  logic                        in_dump_req;
  logic                        in_dump_ready;
  logic                        out_dump_valid;
  logic [REGISTERNO_WIDTH-1:0] out_dump_regno;
  logic [REGISTER_WIDTH-1:0]   out_dump_value;
  logic                        out_dump_done;

  modport slave (
    input  in_dump_req,
    input  in_dump_ready,
    output out_dump_valid,
    output out_dump_regno,
    output out_dump_value,
    output out_dump_done
  );

  modport master (
    output in_dump_req,
    output in_dump_ready,
    input  out_dump_valid,
    input  out_dump_regno,
    input  out_dump_value,
    input  out_dump_done
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-read-port register file with busy scoreboard and a
// handshaked register dump stream.
//   clk, reset_n       : clock (rising edge) / asynchronous active-low reset
//   in_wr_enable, in_rd_regno, in_rd_value : write port (index 0 discarded)
//   in_rs_regno, out_rs_value, out_rs_busy : NUM_READ combinational read
//                        ports, port k in slice k; index 0 reads 0, never busy
//   in_reserve_enable, in_reserve_regno    : mark a register busy
//   dump (regfile_mp_if.slave)             : dump request, valid/ready beat
//                        stream of all registers in index order, done pulse
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and a cleared busy bit) to matching read ports.
module regfile_mp #(
  parameter int unsigned REGISTER_WIDTH   = 64,
  parameter int unsigned REGISTERNO_WIDTH = 5,
  parameter int unsigned NUM_READ         = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 in_wr_enable,
  input  logic [REGISTERNO_WIDTH-1:0]          in_rd_regno,
  input  logic [REGISTER_WIDTH-1:0]            in_rd_value,
  input  logic [NUM_READ*REGISTERNO_WIDTH-1:0] in_rs_regno,
  output logic [NUM_READ*REGISTER_WIDTH-1:0]   out_rs_value,
  output logic [NUM_READ-1:0]                  out_rs_busy,
  input  logic                                 in_reserve_enable,
  input  logic [REGISTERNO_WIDTH-1:0]          in_reserve_regno,
  regfile_mp_if.slave                          dump
);

  localparam int unsigned NREG = 2 ** REGISTERNO_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    DUMP,
    DONE
  } dump_state_e;

  logic [REGISTER_WIDTH-1:0]   regs [NREG];
  logic [NREG-1:0]             busy_q;
  dump_state_e                 state_q, state_d;
  logic [REGISTERNO_WIDTH-1:0] cnt_q, cnt_d;
  logic [REGISTERNO_WIDTH-1:0] rs_idx;
  logic                        wr_valid;

  assign wr_valid = in_wr_enable && (in_rd_regno != '0);

  // Array and scoreboard. The reserve is applied after the write-clear so a
  // same-cycle reserve of the written index leaves the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_valid) begin
        regs[in_rd_regno]   <= in_rd_value;
        busy_q[in_rd_regno] <= 1'b0;
      end
      if (in_reserve_enable && (in_reserve_regno != '0)) begin
        busy_q[in_reserve_regno] <= 1'b1;
      end
    end
  end

  // Read ports
  always_comb begin
    out_rs_value = '0;
    out_rs_busy  = '0;
    rs_idx       = '0;
    for (int unsigned k = 0; k < NUM_READ; k++) begin
      rs_idx = in_rs_regno[k*REGISTERNO_WIDTH +: REGISTERNO_WIDTH];
      if (rs_idx != '0) begin
        out_rs_value[k*REGISTER_WIDTH +: REGISTER_WIDTH] = regs[rs_idx];
        out_rs_busy[k]                                   = busy_q[rs_idx];
`ifdef REGFILE_BYPASS_EN
        if (in_wr_enable && (rs_idx == in_rd_regno)) begin
          out_rs_value[k*REGISTER_WIDTH +: REGISTER_WIDTH] = in_rd_value;
          out_rs_busy[k]                                   = 1'b0;
        end
`endif
      end
    end
  end

  // Dump FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Dump FSM next state and outputs
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    dump.out_dump_valid = 1'b0;
    dump.out_dump_done  = 1'b0;
    dump.out_dump_regno = cnt_q;
    dump.out_dump_value = '0;
    case (state_q)
      IDLE: begin
        if (dump.in_dump_req) begin
          state_d = DUMP;
          cnt_d   = '0;
        end
      end
      DUMP: begin
        dump.out_dump_valid = 1'b1;
        dump.out_dump_value = regs[cnt_q];
        if (dump.in_dump_ready) begin
          if (cnt_q == '1) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        dump.out_dump_done = 1'b1;
        state_d            = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_wr_enable;
  logic [4:0]   in_rd_regno;
  logic [63:0]  in_rd_value;
  logic [9:0]   in_rs_regno;
  logic [127:0] out_rs_value;
  logic [1:0]   out_rs_busy;
  logic         in_reserve_enable;
  logic [4:0]   in_reserve_regno;

  regfile_mp_if #(.REGISTER_WIDTH(64), .REGISTERNO_WIDTH(5)) dump_if ();

  regfile_mp #(
    .REGISTER_WIDTH  (64),
    .REGISTERNO_WIDTH(5),
    .NUM_READ        (2)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_wr_enable     (in_wr_enable),
    .in_rd_regno      (in_rd_regno),
    .in_rd_value      (in_rd_value),
    .in_rs_regno      (in_rs_regno),
    .out_rs_value     (out_rs_value),
    .out_rs_busy      (out_rs_busy),
    .in_reserve_enable(in_reserve_enable),
    .in_reserve_regno (in_reserve_regno),
    .dump             (dump_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [63:0] val;
    logic        res;
    logic [4:0]  resr;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [63:0] e0;
    logic [63:0] e1;
    logic        eb0;
    logic        eb1;
  } vec_t;

  vec_t        vt [17];
  logic [63:0] model [32];
  logic [63:0] bigv;

  initial begin
    bigv = 64'hDEAD_BEEF_CAFE_F00D;
    // values/busy are the pre-edge view in the vector's own cycle
    //          wr    rd     val            res   resr   rs0    rs1    e0             e1             eb0   eb1
    vt[0]  = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  5'd5,  5'd0,  64'h0,         64'h0,         1'b0, 1'b0};
    vt[1]  = '{1'b1, 5'd5,  64'h1234,      1'b0, 5'd0,  5'd1,  5'd0,  64'h0,         64'h0,         1'b0, 1'b0};
    vt[2]  = '{1'b1, 5'd0,  64'hFF,        1'b0, 5'd0,  5'd5,  5'd0,  64'h1234,      64'h0,         1'b0, 1'b0};
    vt[3]  = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  5'd0,  5'd5,  64'h0,         64'h1234,      1'b0, 1'b0};
    vt[4]  = '{1'b0, 5'd0,  64'h0,         1'b1, 5'd7,  5'd7,  5'd5,  64'h0,         64'h1234,      1'b0, 1'b0};
    vt[5]  = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  5'd7,  5'd0,  64'h0,         64'h0,         1'b1, 1'b0};
    vt[6]  = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  5'd0,  5'd7,  64'h0,         64'h0,         1'b0, 1'b1};
    vt[7]  = '{1'b1, 5'd7,  64'h9,         1'b0, 5'd0,  5'd5,  5'd3,  64'h1234,      64'h0,         1'b0, 1'b0};
    vt[8]  = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  5'd7,  5'd0,  64'h9,         64'h0,         1'b0, 1'b0};
    vt[9]  = '{1'b1, 5'd7,  64'h55,        1'b1, 5'd7,  5'd5,  5'd0,  64'h1234,      64'h0,         1'b0, 1'b0};
    vt[10] = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  5'd7,  5'd5,  64'h55,        64'h1234,      1'b1, 1'b0};
    vt[11] = '{1'b1, 5'd7,  64'h66,        1'b0, 5'd0,  5'd5,  5'd0,  64'h1234,      64'h0,         1'b0, 1'b0};
    vt[12] = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  5'd7,  5'd7,  64'h66,        64'h66,        1'b0, 1'b0};
    vt[13] = '{1'b0, 5'd0,  64'h0,         1'b1, 5'd0,  5'd1,  5'd2,  64'h0,         64'h0,         1'b0, 1'b0};
    vt[14] = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  5'd0,  5'd0,  64'h0,         64'h0,         1'b0, 1'b0};
    vt[15] = '{1'b1, 5'd31, bigv,          1'b0, 5'd0,  5'd1,  5'd2,  64'h0,         64'h0,         1'b0, 1'b0};
    vt[16] = '{1'b0, 5'd0,  64'h0,         1'b0, 5'd0,  5'd31, 5'd30, bigv,          64'h0,         1'b0, 1'b0};

    reset_n                = 1'b0;
    in_wr_enable           = 1'b0;
    in_rd_regno            = '0;
    in_rd_value            = '0;
    in_rs_regno            = '0;
    in_reserve_enable      = 1'b0;
    in_reserve_regno       = '0;
    dump_if.in_dump_req    = 1'b0;
    dump_if.in_dump_ready  = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    in_rs_regno = {5'd9, 5'd4};
    #1;
    chk("rst_valid", {63'd0, dump_if.out_dump_valid}, 64'd0);
    chk("rst_done",  {63'd0, dump_if.out_dump_done}, 64'd0);
    chk("rst_regno", {59'd0, dump_if.out_dump_regno}, 64'd0);
    chk("rst_value", dump_if.out_dump_value, 64'd0);
    chk("rst_rd0",   out_rs_value[63:0], 64'd0);
    chk("rst_busy",  {62'd0, out_rs_busy}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // table-driven write/read/reserve vectors
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      in_wr_enable      = vt[i].wr;
      in_rd_regno       = vt[i].rd;
      in_rd_value       = vt[i].val;
      in_reserve_enable = vt[i].res;
      in_reserve_regno  = vt[i].resr;
      in_rs_regno       = {vt[i].rs1, vt[i].rs0};
      #1;
      chk($sformatf("v%0d_val0", i),  out_rs_value[63:0],   vt[i].e0);
      chk($sformatf("v%0d_val1", i),  out_rs_value[127:64], vt[i].e1);
      chk($sformatf("v%0d_busy0", i), {63'd0, out_rs_busy[0]}, {63'd0, vt[i].eb0});
      chk($sformatf("v%0d_busy1", i), {63'd0, out_rs_busy[1]}, {63'd0, vt[i].eb1});
    end

    // same-cycle write/read of r3 (r3 reserved first so busy is visible)
    @(negedge clk);
    in_wr_enable      = 1'b0;
    in_reserve_enable = 1'b1;
    in_reserve_regno  = 5'd3;
    @(negedge clk);
    in_reserve_enable = 1'b0;
    in_wr_enable      = 1'b1;
    in_rd_regno       = 5'd3;
    in_rd_value       = 64'hAA;
    in_rs_regno       = {5'd3, 5'd5};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_val1",  out_rs_value[127:64], 64'hAA);
    chk("byp_busy1", {63'd0, out_rs_busy[1]}, 64'd0);
`else
    chk("byp_val1",  out_rs_value[127:64], 64'h0);
    chk("byp_busy1", {63'd0, out_rs_busy[1]}, 64'd1);
`endif
    chk("byp_val0", out_rs_value[63:0], 64'h1234);
    @(negedge clk);
    in_wr_enable = 1'b0;
    #1;
    chk("byp_after_val",  out_rs_value[127:64], 64'hAA);
    chk("byp_after_busy", {63'd0, out_rs_busy[1]}, 64'd0);

    // fill every register with a distinct value for the dump
    model[0] = '0;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      model[i]     = 64'hC0DE_0000_0000_0000 | (64'(i) << 32) | 64'(i * 17);
      in_wr_enable = 1'b1;
      in_rd_regno  = 5'(i);
      in_rd_value  = model[i];
    end

    // dump with ready pattern 1,0,1,1,0,1...; request held into DUMP (ignored);
    // r20 rewritten mid-dump, ahead of its beat
    @(negedge clk);
    in_wr_enable        = 1'b0;
    dump_if.in_dump_req = 1'b1;
    begin
      int beat;
      int cyc;
      bit finished;
      beat     = 0;
      cyc      = 0;
      finished = 0;
      while (!finished && cyc < 300) begin
        @(negedge clk);
        cyc++;
        dump_if.in_dump_ready = ((cyc % 3) != 2);
        dump_if.in_dump_req   = (cyc < 5);
        in_wr_enable          = (cyc == 3);
        in_rd_regno           = 5'd20;
        in_rd_value           = 64'h77;
        if (cyc == 3) model[20] = 64'h77;
        #1;
        if (dump_if.out_dump_valid) begin
          if (beat > 31) begin
            chk("dump_extra_beat", {63'd0, dump_if.out_dump_valid}, 64'd0);
            finished = 1;
          end else begin
            chk($sformatf("dump_regno_b%0d", beat), {59'd0, dump_if.out_dump_regno}, 64'(beat));
            chk($sformatf("dump_value_b%0d", beat), dump_if.out_dump_value, model[beat]);
            chk("dump_done_early", {63'd0, dump_if.out_dump_done}, 64'd0);
            if (dump_if.in_dump_ready) beat++;
          end
        end else if (beat == 32) begin
          chk("dump_done_pulse", {63'd0, dump_if.out_dump_done}, 64'd1);
          @(negedge clk);
          #1;
          chk("dump_done_width", {63'd0, dump_if.out_dump_done}, 64'd0);
          chk("dump_valid_after", {63'd0, dump_if.out_dump_valid}, 64'd0);
          finished = 1;
        end else begin
          chk("dump_valid_gap", {63'd0, dump_if.out_dump_valid}, 64'd1);
          finished = 1;
        end
      end
      if (!finished) chk("dump_timeout", 64'(cyc), 64'd0);
    end

    // reset in the middle of a dump at regno 10
    @(negedge clk);
    in_wr_enable          = 1'b0;
    dump_if.in_dump_ready = 1'b1;
    dump_if.in_dump_req   = 1'b1;
    begin
      int cyc;
      bit hit;
      cyc = 0;
      hit = 0;
      while (!hit && cyc < 100) begin
        @(negedge clk);
        cyc++;
        dump_if.in_dump_req = 1'b0;
        #1;
        if (dump_if.out_dump_valid && dump_if.out_dump_regno == 5'd10) hit = 1;
      end
      if (!hit) chk("abort_reach_r10", 64'(cyc), 64'd0);
    end
    reset_n = 1'b0;
    #1;
    chk("abort_valid", {63'd0, dump_if.out_dump_valid}, 64'd0);
    chk("abort_regno", {59'd0, dump_if.out_dump_regno}, 64'd0);
    chk("abort_value", dump_if.out_dump_value, 64'd0);
    chk("abort_done",  {63'd0, dump_if.out_dump_done}, 64'd0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("abort_done_hold", {63'd0, dump_if.out_dump_done}, 64'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      in_rs_regno = {5'(31 - i), 5'(i)};
      #1;
      chk($sformatf("post_rst_r%0d", i), out_rs_value[63:0], 64'd0);
      chk($sformatf("post_rst_r%0d_p1", 31 - i), out_rs_value[127:64], 64'd0);
      chk("post_rst_busy", {62'd0, out_rs_busy}, 64'd0);
      chk("post_rst_done", {63'd0, dump_if.out_dump_done}, 64'd0);
      chk("post_rst_valid", {63'd0, dump_if.out_dump_valid}, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter REGISTER_WIDTH, default 64, the data width of each register.
REQ-002 SHALL have parameter REGISTERNO_WIDTH, default 5, the register index width; depth NREG = 2**REGISTERNO_WIDTH.
REQ-003 SHALL have parameter NUM_READ, default 2, the number of independent read ports (>=1).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_wr_enable  input  1  write strobe.
REQ-007 SHALL have port in_rd_regno  input  REGISTERNO_WIDTH  write index.
REQ-008 SHALL have port in_rd_value  input  REGISTER_WIDTH  write data.
REQ-009 SHALL have port in_rs_regno  input  NUM_READ*REGISTERNO_WIDTH  read indices, port k in slice k.
REQ-010 SHALL have port out_rs_value  output  NUM_READ*REGISTER_WIDTH  read data, port k in slice k.
REQ-011 SHALL have port out_rs_busy  output  NUM_READ  scoreboard busy bit per read port.
REQ-012 SHALL have port in_reserve_enable  input  1  mark a register busy (pending producer).
REQ-013 SHALL have port in_reserve_regno  input  REGISTERNO_WIDTH  register to mark busy.
REQ-014 SHALL have port in_dump_req  input  1  start a register dump.
REQ-015 SHALL have ports out_dump_valid (output, 1), in_dump_ready (input, 1), out_dump_regno (output, REGISTERNO_WIDTH), out_dump_value (output, REGISTER_WIDTH)  dump stream.
REQ-016 SHALL have port out_dump_done  output  1  one-cycle pulse after the last dump beat.

Function
REQ-017 SHALL write in_rd_value to register in_rd_regno at the clock edge where in_wr_enable=1 and in_rd_regno!=0; writes to index 0 are discarded.
REQ-018 SHALL drive each read port combinationally from the array; index 0 always reads 0 and is never busy.
REQ-019 SHALL set busy[in_reserve_regno] at the edge where in_reserve_enable=1 and index!=0.
REQ-020 SHALL clear busy[in_rd_regno] on a valid write (REQ-017).
REQ-021 SHALL, when reserve and write target the same index in one cycle, store the data and leave busy set (reserve wins).
REQ-022 SHALL implement dump FSM states IDLE, DUMP, DONE: IDLE->DUMP on in_dump_req with index counter 0; DUMP->DONE on the handshake of index NREG-1; DONE->IDLE after one cycle.
REQ-023 SHALL assert out_dump_valid only in DUMP, presenting the counter on out_dump_regno and the stored array value (no bypass) on out_dump_value.
REQ-024 SHALL advance the counter only on out_dump_valid&&in_dump_ready; valid, regno and value SHALL hold stable while ready=0.
REQ-025 SHALL ignore in_dump_req outside IDLE; writes and reserves remain accepted during a dump, and a dumped value reflects the array at its handshake cycle.
REQ-026 SHALL assert out_dump_done only in DONE, for exactly one cycle.

Reset
REQ-027 SHALL, on reset_n=0 and independent of clk, clear all registers and busy bits, force FSM to IDLE and counter to 0, with out_dump_valid=0, out_dump_done=0, out_dump_regno=0, out_dump_value=0.
REQ-028 SHALL abort a dump in progress on reset with no out_dump_done pulse; operation resumes on the first edge after reset_n rises.

Configuration
REQ-029 SHALL, with macro REGFILE_BYPASS_EN defined, forward in_rd_value to any read port whose nonzero index equals in_rd_regno while in_wr_enable=1, and report that port not busy in the same cycle.
REQ-030 SHALL, without REGFILE_BYPASS_EN, return the old value and old busy bit on such reads until the following cycle.

Verification
REQ-031 Reset, write r5=0x1234, read r5 next cycle -> 0x1234; write r0=0xFF -> r0 reads 0.
REQ-032 Reserve r7, then write r7=9 three cycles later -> busy 1 for those cycles, 0 after; reserve+write r7 same cycle -> busy stays 1, value stored.
REQ-033 Write r3=0xAA while port 1 reads r3 -> 0xAA same cycle with REGFILE_BYPASS_EN, old value 0 without.
REQ-034 Dump with ready toggled 1,0,1 -> 32 beats regno 0..31 in order, values stable while ready=0, one-cycle done pulse after beat 31.
REQ-035 Assert reset_n=0 mid-dump at regno 10 -> valid drops immediately, no done pulse, all registers read 0 afterward.
